// File: rtl/rs_age_multi_issue_pkg.sv
// Shared definitions for the age-ordered multi-issue reservation station.
// The defaults are the R10K configuration. RS_ENTRY_T is the entry layout at the default widths.
package rs_age_multi_issue_pkg;

  localparam int RS_NUM_ENTRY = 16;
  localparam int RS_DISP_W    = 3;
  localparam int RS_ISSUE_W   = 3;
  localparam int RS_CDB_W     = 3;
  localparam int RS_PRN_W     = 6;
  localparam int RS_PAYLOAD_W = 64;

  typedef struct packed {
    logic                    valid;
    logic [RS_PRN_W-1:0]     src1_prn;
    logic                    src1_rdy;
    logic [RS_PRN_W-1:0]     src2_prn;
    logic                    src2_rdy;
    logic [RS_PAYLOAD_W-1:0] payload;
  } RS_ENTRY_T;

endpackage

// File: rtl/rs_age_picker.sv
// Oldest-first selector. Each eligible entry is ranked by the number of older eligible entries.
// The n-th non-stalled port is granted the entry of rank n.
module rs_age_picker
  import rs_age_multi_issue_pkg::*;
#(
  parameter int NUM_ENTRY = RS_NUM_ENTRY,
  parameter int ISSUE_W   = RS_ISSUE_W
) (
  input  logic [NUM_ENTRY*NUM_ENTRY-1:0] i_age,
  input  logic [NUM_ENTRY-1:0]           i_elig,
  input  logic [ISSUE_W-1:0]             i_stall,
  output logic [ISSUE_W*NUM_ENTRY-1:0]   o_grant
);

  localparam int CNT_W = $clog2(NUM_ENTRY + 1);

  logic [CNT_W-1:0] w_rank [NUM_ENTRY];

  always_comb begin
    for (int e = 0; e < NUM_ENTRY; e++) begin
      w_rank[e] = CNT_W'($countones(i_age[e*NUM_ENTRY +: NUM_ENTRY] & i_elig));
    end
  end

  // The age order is total, so each rank belongs to at most one eligible entry.
  always_comb begin
    int slot;
    slot    = 0;
    o_grant = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (!i_stall[k]) begin
        for (int e = 0; e < NUM_ENTRY; e++) begin
          if (i_elig[e] && int'(w_rank[e]) == slot) o_grant[k*NUM_ENTRY + e] = 1'b1;
        end
        slot++;
      end
    end
  end

endmodule

// File: rtl/rs_age_multi_issue.sv
// Reservation station: dispatch into the lowest free entries, CDB wakeup with dispatch forwarding,
// age-matrix oldest-first issue to ISSUE_W ports with registered outputs, squash flush.
module rs_age_multi_issue
  import rs_age_multi_issue_pkg::*;
#(
  parameter int NUM_ENTRY = RS_NUM_ENTRY,
  parameter int DISP_W    = RS_DISP_W,
  parameter int ISSUE_W   = RS_ISSUE_W,
  parameter int CDB_W     = RS_CDB_W,
  parameter int PRN_W     = RS_PRN_W,
  parameter int PAYLOAD_W = RS_PAYLOAD_W,
  localparam int CNT_W    = $clog2(NUM_ENTRY + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  logic [DISP_W-1:0]            disp_valid,
  input  logic [DISP_W*PRN_W-1:0]      disp_src1_prn,
  input  logic [DISP_W-1:0]            disp_src1_rdy,
  input  logic [DISP_W*PRN_W-1:0]      disp_src2_prn,
  input  logic [DISP_W-1:0]            disp_src2_rdy,
  input  logic [DISP_W*PAYLOAD_W-1:0]  disp_payload,
  input  logic [CDB_W-1:0]             cdb_valid,
  input  logic [CDB_W*PRN_W-1:0]       cdb_tag,
  input  logic [ISSUE_W-1:0]           issue_stall,
  output logic [DISP_W-1:0]            struct_stall,
  output logic [ISSUE_W-1:0]           issue_valid,
  output logic [ISSUE_W*PRN_W-1:0]     issue_src1_prn,
  output logic [ISSUE_W*PRN_W-1:0]     issue_src2_prn,
  output logic [ISSUE_W*PAYLOAD_W-1:0] issue_payload,
  output logic [CNT_W-1:0]             free_cnt
);

  typedef struct packed {
    logic                 valid;
    logic [PRN_W-1:0]     src1_prn;
    logic                 src1_rdy;
    logic [PRN_W-1:0]     src2_prn;
    logic                 src2_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t                       r_entry [NUM_ENTRY];
  logic [NUM_ENTRY-1:0]         r_age   [NUM_ENTRY];
  logic [CNT_W-1:0]             r_free_cnt;
  logic [ISSUE_W-1:0]           r_issue_valid;
  logic [ISSUE_W*PRN_W-1:0]     r_issue_src1;
  logic [ISSUE_W*PRN_W-1:0]     r_issue_src2;
  logic [ISSUE_W*PAYLOAD_W-1:0] r_issue_payload;

  logic [NUM_ENTRY-1:0]           w_valid, w_elig, w_issued, w_alloc, w_wake1, w_wake2;
  logic [DISP_W-1:0]              w_stall, w_acc;
  logic [NUM_ENTRY-1:0]           w_lane_oh  [DISP_W];
  logic [NUM_ENTRY-1:0]           w_lane_row [DISP_W];
  entry_t                         w_lane_entry [DISP_W];
  logic [NUM_ENTRY*NUM_ENTRY-1:0] w_age_flat;
  logic [ISSUE_W*NUM_ENTRY-1:0]   w_grant;
  logic [ISSUE_W-1:0]             w_iss_valid;
  logic [ISSUE_W*PRN_W-1:0]       w_iss_src1, w_iss_src2;
  logic [ISSUE_W*PAYLOAD_W-1:0]   w_iss_payload;
  logic [CNT_W-1:0]               w_acc_cnt, w_iss_cnt;

  function automatic logic cdb_match(input logic [PRN_W-1:0]       tag,
                                     input logic [CDB_W-1:0]       vld,
                                     input logic [CDB_W*PRN_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_W; k++) begin
      if (vld[k] && tags[k*PRN_W +: PRN_W] == tag) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    for (int e = 0; e < NUM_ENTRY; e++) begin
      w_valid[e] = r_entry[e].valid;
      w_elig[e]  = r_entry[e].valid && r_entry[e].src1_rdy && r_entry[e].src2_rdy;
      w_wake1[e] = cdb_match(r_entry[e].src1_prn, cdb_valid, cdb_tag);
      w_wake2[e] = cdb_match(r_entry[e].src2_prn, cdb_valid, cdb_tag);
      w_age_flat[e*NUM_ENTRY +: NUM_ENTRY] = r_age[e];
    end
  end

  // Stall depends only on registered free_cnt, never on this cycle's issue.
  always_comb begin
    int seen;
    seen = 0;
    for (int i = 0; i < DISP_W; i++) begin
      if (disp_valid[i]) seen++;
      w_stall[i] = disp_valid[i] && (seen > int'(r_free_cnt));
    end
  end

  assign w_acc        = disp_valid & ~w_stall;
  assign struct_stall = w_stall;

  always_comb begin
    for (int i = 0; i < DISP_W; i++) begin
      w_lane_entry[i].valid    = 1'b1;
      w_lane_entry[i].src1_prn = disp_src1_prn[i*PRN_W +: PRN_W];
      w_lane_entry[i].src1_rdy = disp_src1_rdy[i] ||
                                 cdb_match(disp_src1_prn[i*PRN_W +: PRN_W], cdb_valid, cdb_tag);
      w_lane_entry[i].src2_prn = disp_src2_prn[i*PRN_W +: PRN_W];
      w_lane_entry[i].src2_rdy = disp_src2_rdy[i] ||
                                 cdb_match(disp_src2_prn[i*PRN_W +: PRN_W], cdb_valid, cdb_tag);
      w_lane_entry[i].payload  = disp_payload[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  // Lane i takes the lowest still-free entry. Its age row covers every surviving entry and all earlier lanes.
  // Entries freed by issue this cycle are still valid here, so they cannot be reused until next cycle.
  always_comb begin
    logic [NUM_ENTRY-1:0] avail, older;
    avail   = ~w_valid;
    older   = w_valid & ~w_issued;
    w_alloc = '0;
    for (int i = 0; i < DISP_W; i++) begin
      w_lane_oh[i] = '0;
      if (w_acc[i]) w_lane_oh[i] = avail & (~avail + NUM_ENTRY'(1));
      w_lane_row[i] = older;
      avail   = avail & ~w_lane_oh[i];
      older   = older | w_lane_oh[i];
      w_alloc = w_alloc | w_lane_oh[i];
    end
  end

  rs_age_picker #(
    .NUM_ENTRY (NUM_ENTRY),
    .ISSUE_W   (ISSUE_W)
  ) u_picker (
    .i_age   (w_age_flat),
    .i_elig  (w_elig),
    .i_stall (issue_stall),
    .o_grant (w_grant)
  );

  always_comb begin
    w_issued      = '0;
    w_iss_valid   = '0;
    w_iss_src1    = '0;
    w_iss_src2    = '0;
    w_iss_payload = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        if (w_grant[k*NUM_ENTRY + e]) begin
          w_issued[e]                               = 1'b1;
          w_iss_valid[k]                            = 1'b1;
          w_iss_src1[k*PRN_W +: PRN_W]              = r_entry[e].src1_prn;
          w_iss_src2[k*PRN_W +: PRN_W]              = r_entry[e].src2_prn;
          w_iss_payload[k*PAYLOAD_W +: PAYLOAD_W]   = r_entry[e].payload;
        end
      end
    end
  end

  assign w_acc_cnt = CNT_W'($countones(w_acc));
  assign w_iss_cnt = CNT_W'($countones(w_issued));

  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: the whole entry array and age matrix are cleared, not just the valid bits.
      // Reset must leave issue data and all state at zero, and these are flops rather than a RAM macro.
      for (int e = 0; e < NUM_ENTRY; e++) begin
        r_entry[e] <= '0;
        r_age[e]   <= '0;
      end
      r_free_cnt      <= CNT_W'(NUM_ENTRY);
      r_issue_valid   <= '0;
      r_issue_src1    <= '0;
      r_issue_src2    <= '0;
      r_issue_payload <= '0;
    end else if (squash) begin
      // Stale age bits are harmless: rank masks them with eligibility, and reallocation rewrites them.
      for (int e = 0; e < NUM_ENTRY; e++) r_entry[e].valid <= 1'b0;
      r_free_cnt    <= CNT_W'(NUM_ENTRY);
      r_issue_valid <= '0;
    end else begin
      r_free_cnt      <= r_free_cnt - w_acc_cnt + w_iss_cnt;
      r_issue_valid   <= w_iss_valid;
      r_issue_src1    <= w_iss_src1;
      r_issue_src2    <= w_iss_src2;
      r_issue_payload <= w_iss_payload;
      for (int e = 0; e < NUM_ENTRY; e++) begin
        if (w_issued[e]) begin
          r_entry[e].valid <= 1'b0;
        end else if (w_valid[e]) begin
          if (w_wake1[e]) r_entry[e].src1_rdy <= 1'b1;
          if (w_wake2[e]) r_entry[e].src2_rdy <= 1'b1;
        end
        for (int i = 0; i < DISP_W; i++) begin
          if (w_lane_oh[i][e]) begin
            r_entry[e] <= w_lane_entry[i];
            r_age[e]   <= w_lane_row[i];
          end
        end
        // A newly allocated entry is younger than every entry already present.
        for (int j = 0; j < NUM_ENTRY; j++) begin
          if (w_alloc[j] && !w_alloc[e]) r_age[e][j] <= 1'b0;
        end
      end
    end
  end

  assign issue_valid    = r_issue_valid;
  assign issue_src1_prn = r_issue_src1;
  assign issue_src2_prn = r_issue_src2;
  assign issue_payload  = r_issue_payload;
  assign free_cnt       = r_free_cnt;

endmodule

// File: tb/tb_rs_age_multi_issue.sv
// Bench for rs_age_multi_issue: directed scenarios, then randomized traffic.
// All checks run against an age-ordered queue model.
module tb_rs_age_multi_issue;

  localparam int NE = 16, DW = 3, IW = 3, CW = 3, PW = 6, YW = 64;

  logic              clock = 1'b0;
  logic              reset, squash;
  logic [DW-1:0]     disp_valid, disp_src1_rdy, disp_src2_rdy;
  logic [DW*PW-1:0]  disp_src1_prn, disp_src2_prn;
  logic [DW*YW-1:0]  disp_payload;
  logic [CW-1:0]     cdb_valid;
  logic [CW*PW-1:0]  cdb_tag;
  logic [IW-1:0]     issue_stall;
  logic [DW-1:0]     struct_stall;
  logic [IW-1:0]     issue_valid;
  logic [IW*PW-1:0]  issue_src1_prn, issue_src2_prn;
  logic [IW*YW-1:0]  issue_payload;
  logic [4:0]        free_cnt;

  always #5 clock = ~clock;

  rs_age_multi_issue dut (
    .clock          (clock),
    .reset          (reset),
    .squash         (squash),
    .disp_valid     (disp_valid),
    .disp_src1_prn  (disp_src1_prn),
    .disp_src1_rdy  (disp_src1_rdy),
    .disp_src2_prn  (disp_src2_prn),
    .disp_src2_rdy  (disp_src2_rdy),
    .disp_payload   (disp_payload),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .issue_stall    (issue_stall),
    .struct_stall   (struct_stall),
    .issue_valid    (issue_valid),
    .issue_src1_prn (issue_src1_prn),
    .issue_src2_prn (issue_src2_prn),
    .issue_payload  (issue_payload),
    .free_cnt       (free_cnt)
  );

  // Model: the queue holds live instructions, oldest at the front.
  typedef struct {
    logic [PW-1:0] s1;
    bit            r1;
    logic [PW-1:0] s2;
    bit            r2;
    logic [YW-1:0] pay;
  } rec_t;

  rec_t          q[$];
  logic [IW-1:0] exp_iv;
  logic [PW-1:0] exp_s1 [IW];
  logic [PW-1:0] exp_s2 [IW];
  logic [YW-1:0] exp_pay [IW];
  logic [DW-1:0] last_stall;
  int            n_checks = 0;
  int            n_fail   = 0;
  int unsigned   uid      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit cdb_hit(input logic [PW-1:0] t);
    for (int k = 0; k < CW; k++) begin
      if (cdb_valid[k] && cdb_tag[k*PW +: PW] == t) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic idle();
    reset = 1'b1; squash = 1'b0;
    disp_valid = '0; disp_src1_rdy = '0; disp_src2_rdy = '0;
    disp_src1_prn = '0; disp_src2_prn = '0; disp_payload = '0;
    cdb_valid = '0; cdb_tag = '0; issue_stall = '0;
  endtask

  task automatic set_lane(input int i, input bit v, input logic [PW-1:0] s1, input bit r1,
                          input logic [PW-1:0] s2, input bit r2);
    uid++;
    disp_valid[i]               = v;
    disp_src1_prn[i*PW +: PW]   = s1;
    disp_src1_rdy[i]            = r1;
    disp_src2_prn[i*PW +: PW]   = s2;
    disp_src2_rdy[i]            = r2;
    disp_payload[i*YW +: YW]    = {32'($urandom()), uid};
  endtask

  task automatic set_cdb(input int k, input bit v, input logic [PW-1:0] t);
    cdb_valid[k]        = v;
    cdb_tag[k*PW +: PW] = t;
  endtask

  // One clock: check stall against the model, advance the model, then check registered outputs.
  task automatic step();
    logic [DW-1:0] exp_stall;
    int            free_now, seen, ei;
    int            elig[$];
    bit            taken[NE];
    rec_t          nq[$];
    rec_t          r;
    bit            chk_data;
    #1;
    free_now = NE - q.size();
    seen = 0;
    for (int i = 0; i < DW; i++) begin
      if (disp_valid[i]) seen++;
      exp_stall[i] = disp_valid[i] && (seen > free_now);
    end
    last_stall = struct_stall;
    check("struct_stall", struct_stall, exp_stall);
    chk_data = 1'b0;
    for (int e = 0; e < NE; e++) taken[e] = 1'b0;
    if (!reset) begin
      q.delete();
      exp_iv   = '0;
      chk_data = 1'b1;
      for (int k = 0; k < IW; k++) begin
        exp_s1[k] = '0; exp_s2[k] = '0; exp_pay[k] = '0;
      end
    end else if (squash) begin
      q.delete();
      exp_iv = '0;
    end else begin
      for (int e = 0; e < q.size(); e++) if (q[e].r1 && q[e].r2) elig.push_back(e);
      ei = 0;
      for (int k = 0; k < IW; k++) begin
        exp_iv[k] = 1'b0;
        if (!issue_stall[k] && ei < elig.size()) begin
          r = q[elig[ei]];
          taken[elig[ei]] = 1'b1;
          exp_iv[k] = 1'b1; exp_s1[k] = r.s1; exp_s2[k] = r.s2; exp_pay[k] = r.pay;
          ei++;
        end
      end
      for (int e = 0; e < q.size(); e++) begin
        if (!taken[e]) begin
          r = q[e];
          if (cdb_hit(r.s1)) r.r1 = 1'b1;
          if (cdb_hit(r.s2)) r.r2 = 1'b1;
          nq.push_back(r);
        end
      end
      for (int i = 0; i < DW; i++) begin
        if (disp_valid[i] && !exp_stall[i]) begin
          r.s1  = disp_src1_prn[i*PW +: PW];
          r.s2  = disp_src2_prn[i*PW +: PW];
          r.r1  = disp_src1_rdy[i] || cdb_hit(r.s1);
          r.r2  = disp_src2_rdy[i] || cdb_hit(r.s2);
          r.pay = disp_payload[i*YW +: YW];
          nq.push_back(r);
        end
      end
      q = nq;
    end
    @(posedge clock);
    #1;
    check("issue_valid", issue_valid, exp_iv);
    for (int k = 0; k < IW; k++) begin
      if (exp_iv[k] || chk_data) begin
        check($sformatf("p%0d_src1", k), issue_src1_prn[k*PW +: PW], exp_s1[k]);
        check($sformatf("p%0d_src2", k), issue_src2_prn[k*PW +: PW], exp_s2[k]);
        check($sformatf("p%0d_payload", k), issue_payload[k*YW +: YW], exp_pay[k]);
      end
    end
    check("free_cnt", free_cnt, 64'(NE - q.size()));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit busy;
    int exp_free;

    // Reset held two cycles; all lanes offered in the second reset cycle must not stall or stick.
    idle(); reset = 1'b0;
    step();
    idle(); reset = 1'b0;
    set_lane(0, 1, 6'd7, 1, 6'd8, 1); set_lane(1, 1, 6'd7, 1, 6'd8, 1); set_lane(2, 1, 6'd7, 1, 6'd8, 1);
    step();
    check("rst_stall", last_stall, 3'b000);
    check("rst_free", free_cnt, 16);
    check("rst_issue_valid", issue_valid, 3'b000);

    // Ready dispatch issues on port 0 one cycle after it lands in the station.
    idle(); set_lane(0, 1, 6'd1, 1, 6'd2, 1);
    step();
    idle(); step();
    check("t2_issue_valid", issue_valid, 3'b001);
    check("t2_src1", issue_src1_prn[PW-1:0], 6'd1);
    check("t2_src2", issue_src2_prn[PW-1:0], 6'd2);
    check("t2_free", free_cnt, 16);

    // Forwarding on dispatch for src1; src2 woken later, issue two cycles after that CDB.
    idle(); set_lane(0, 1, 6'd3, 0, 6'd4, 0); set_cdb(0, 1, 6'd3);
    step();
    idle(); step();
    check("t3_no_issue", issue_valid, 3'b000);
    idle(); set_cdb(0, 1, 6'd4);
    step();
    idle(); step();
    check("t3_issue_after_cdb", issue_valid, 3'b001);

    // Fill to full, then overflow; then wake everything and drain 3 per cycle.
    for (int c = 0; c < 6; c++) begin
      idle();
      for (int i = 0; i < DW; i++) set_lane(i, 1, 6'd5, 0, 6'd6, 0);
      step();
    end
    check("t4_full_free", free_cnt, 0);
    idle();
    for (int i = 0; i < DW; i++) set_lane(i, 1, 6'd5, 0, 6'd6, 0);
    step();
    check("t4_full_stall", last_stall, 3'b111);
    idle(); set_cdb(0, 1, 6'd5); set_cdb(1, 1, 6'd6);
    step();
    for (int n = 0; n < 6; n++) begin
      idle(); step();
      exp_free = (3 * (n + 1) > 16) ? 16 : 3 * (n + 1);
      check("t4_drain_free", free_cnt, 64'(exp_free));
    end

    // Five ready entries held back, then port 0 stalled: oldest two go to ports 1 and 2.
    idle(); issue_stall = 3'b111;
    for (int i = 0; i < DW; i++) set_lane(i, 1, 6'd1, 1, 6'd2, 1);
    step();
    idle(); issue_stall = 3'b111;
    set_lane(0, 1, 6'd1, 1, 6'd2, 1); set_lane(1, 1, 6'd1, 1, 6'd2, 1);
    step();
    idle(); issue_stall = 3'b111; step();
    idle(); issue_stall = 3'b001; step();
    check("t5_port_stall", issue_valid, 3'b110);
    for (int n = 0; n < 3; n++) begin idle(); step(); end

    // Squash with a simultaneous dispatch drops everything, including that dispatch.
    idle();
    for (int i = 0; i < DW; i++) set_lane(i, 1, 6'd9, 0, 6'd10, 0);
    step();
    idle(); squash = 1'b1; set_lane(0, 1, 6'd1, 1, 6'd2, 1);
    step();
    check("t6_free", free_cnt, 16);
    check("t6_issue_valid", issue_valid, 3'b000);
    idle(); step();
    check("t6_not_retained", issue_valid, 3'b000);

    // Randomized traffic: alternating fill-heavy and wakeup-heavy phases, rare squash and reset.
    for (int c = 0; c < 2000; c++) begin
      busy = ((c / 150) % 2) == 0;
      idle();
      reset  = ($urandom_range(0, 249) != 0);
      squash = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < DW; i++) begin
        set_lane(i, $urandom_range(0, 3) != 0, PW'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                 PW'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
      end
      for (int k = 0; k < CW; k++) begin
        set_cdb(k, busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0),
                PW'($urandom_range(0, 7)));
      end
      issue_stall = IW'($urandom_range(0, 7)) & IW'($urandom_range(0, 7));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
